// File: rtl/nec_ir_mregs.sv
// Wishbone register bank for a multi-channel NEC IR transceiver: per-channel
// configuration, RX/TX FIFO access windows and a masked level interrupt.
module nec_ir_mregs #(
  parameter int unsigned NCH   = 2,
  parameter int unsigned PSIZE = 16,
  parameter int unsigned ASIZE = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_we_i,
  input  logic [6:0]                wbs_adr_i,
  input  logic [31:0]               wbs_dat_i,
  input  logic [3:0]                wbs_sel_i,
  output logic [31:0]               wbs_dat_o,
  output logic                      wbs_ack_o,
  output logic [NCH-1:0]            cfg_ir_en,
  output logic [NCH-1:0]            cfg_tx_en,
  output logic [NCH-1:0]            cfg_rx_en,
  output logic [NCH-1:0]            cfg_repeat_en,
  output logic [NCH-1:0]            cfg_rx_pol,
  output logic [NCH-1:0]            cfg_tx_pol,
  output logic [2*NCH-1:0]          cfg_tolerance,
  output logic [PSIZE*NCH-1:0]      cfg_multiplier,
  output logic [PSIZE*NCH-1:0]      cfg_divider,
  input  logic [NCH-1:0]            rx_frame_new,
  input  logic [NCH-1:0]            fifo_rx_full,
  input  logic [17*NCH-1:0]         fifo_rx_rdata,
  input  logic [(ASIZE+1)*NCH-1:0]  fifo_rx_occ,
  output logic [NCH-1:0]            fifo_rx_read,
  input  logic [NCH-1:0]            fifo_tx_full,
  input  logic [(ASIZE+1)*NCH-1:0]  fifo_tx_occ,
  output logic [15:0]               fifo_tx_wdata,
  output logic [NCH-1:0]            fifo_tx_write,
  output logic                      irq
);
  localparam int unsigned OW = ASIZE + 1;

  logic             glb_ir_en, irq_en;
  logic [31:0]      irq_status, irq_mask;
  logic [NCH-1:0]   ir_en_q, tx_en_q, rx_en_q, rep_en_q, rx_pol_q, tx_pol_q;
  logic [NCH-1:0]   lost_q, tx_nz_q;
  logic [1:0]       tol_q [NCH];
  logic [PSIZE-1:0] mul_q [NCH];
  logic [PSIZE-1:0] div_q [NCH];

  logic [4:0]       w;
  logic             req, wr;
  logic [NCH-1:0]   ch_hit, rx_nz, tx_nz, rx_rd_hit, tx_wr_hit;
  logic [NCH-1:0]   rx_pop, tx_push, tx_ovf, tx_done, lost_set;
  logic [31:0]      wmask, rdata, clk_wr, st_set, st_clr;
  logic             unused_adr;

  assign w          = wbs_adr_i[6:2];
  assign unused_adr = ^wbs_adr_i[1:0];
  assign req        = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign wr         = req & wbs_we_i;
  assign wmask      = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign ch_hit[c] = (w[4:2] == 3'(c + 1));
    assign rx_nz[c]  = |fifo_rx_occ[OW*c +: OW];
    assign tx_nz[c]  = |fifo_tx_occ[OW*c +: OW];
    assign cfg_tolerance[2*c +: 2]          = tol_q[c];
    assign cfg_multiplier[PSIZE*c +: PSIZE] = mul_q[c];
    assign cfg_divider[PSIZE*c +: PSIZE]    = div_q[c];
  end

  assign cfg_ir_en     = ir_en_q & {NCH{glb_ir_en}};
  assign cfg_tx_en     = tx_en_q;
  assign cfg_rx_en     = rx_en_q;
  assign cfg_repeat_en = rep_en_q;
  assign cfg_rx_pol    = rx_pol_q;
  assign cfg_tx_pol    = tx_pol_q;

  assign rx_rd_hit = (req && !wbs_we_i && w[1:0] == 2'd2) ? ch_hit : '0;
  assign tx_wr_hit = (wr && w[1:0] == 2'd3) ? ch_hit : '0;
  assign rx_pop    = rx_rd_hit & rx_nz;
  assign tx_push   = tx_wr_hit & ~fifo_tx_full;
  assign tx_ovf    = tx_wr_hit & fifo_tx_full;
  assign tx_done   = tx_nz_q & ~tx_nz;
  assign lost_set  = rx_frame_new & fifo_rx_full;
  assign st_clr    = (wr && w == 5'd1) ? (wbs_dat_i & wmask) : '0;

  always_comb begin
    st_set = '0;
    st_set[NCH-1:0]  = rx_frame_new;
    st_set[8 +: NCH] = lost_set;
    st_set[16 +: NCH] = tx_done;
    st_set[24 +: NCH] = tx_ovf;
  end

  always_comb begin
    rdata = '0;
    if (w == 5'd0) rdata = {glb_ir_en, 30'd0, irq_en};
    else if (w == 5'd1) rdata = irq_status;
    else if (w == 5'd2) rdata = irq_mask;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (ch_hit[c]) begin
        case (w[1:0])
          2'd0: rdata = {ir_en_q[c], tx_en_q[c], rx_en_q[c], rep_en_q[c], rx_pol_q[c], tx_pol_q[c],
                         tol_q[c], 16'd0, 4'(fifo_tx_occ[OW*c +: OW]), 4'(fifo_rx_occ[OW*c +: OW])};
          2'd1: rdata = {16'(mul_q[c]), 16'(div_q[c])};
          2'd2: rdata = rx_nz[c] ? {1'b1, fifo_rx_rdata[17*c+16], lost_q[c], 13'd0, fifo_rx_rdata[17*c +: 16]}
                                 : {2'b00, lost_q[c], 29'd0};
          default: rdata = '0;
        endcase
      end
    end
  end

  // On a CLK access rdata holds the current word, so byte merging reuses it
  assign clk_wr = (rdata & ~wmask) | (wbs_dat_i & wmask);

  always_ff @(posedge clk) begin
    if (rst) begin
      wbs_ack_o     <= 1'b0;
      wbs_dat_o     <= '0;
      glb_ir_en     <= 1'b0;
      irq_en        <= 1'b0;
      irq_status    <= '0;
      irq_mask      <= '0;
      irq           <= 1'b0;
      ir_en_q       <= '0;
      tx_en_q       <= '0;
      rx_en_q       <= '0;
      rep_en_q      <= '0;
      rx_pol_q      <= '0;
      tx_pol_q      <= '0;
      lost_q        <= '0;
      tx_nz_q       <= '0;
      fifo_rx_read  <= '0;
      fifo_tx_write <= '0;
      fifo_tx_wdata <= '0;
      for (int unsigned c = 0; c < NCH; c++) begin
        tol_q[c] <= 2'b01;
        mul_q[c] <= '0;
        div_q[c] <= '0;
      end
    end else begin
      wbs_ack_o     <= req;
      fifo_rx_read  <= rx_pop;
      fifo_tx_write <= tx_push;
      tx_nz_q       <= tx_nz;
      lost_q        <= (lost_q & ~rx_rd_hit) | lost_set;
      irq_status    <= (irq_status & ~st_clr) | st_set;
      irq           <= irq_en & |(irq_status & irq_mask);
      if (req) wbs_dat_o <= rdata;
      if (|tx_push) fifo_tx_wdata <= wbs_dat_i[15:0];
      if (wr && w == 5'd0) begin
        if (wbs_sel_i[3]) glb_ir_en <= wbs_dat_i[31];
        if (wbs_sel_i[0]) irq_en    <= wbs_dat_i[0];
      end
      if (wr && w == 5'd2) irq_mask <= (irq_mask & ~wmask) | (wbs_dat_i & wmask);
      for (int unsigned c = 0; c < NCH; c++) begin
        if (wr && ch_hit[c] && w[1:0] == 2'd0 && wbs_sel_i[3]) begin
          ir_en_q[c]  <= wbs_dat_i[31];
          tx_en_q[c]  <= wbs_dat_i[30];
          rx_en_q[c]  <= wbs_dat_i[29];
          rep_en_q[c] <= wbs_dat_i[28];
          rx_pol_q[c] <= wbs_dat_i[27];
          tx_pol_q[c] <= wbs_dat_i[26];
          tol_q[c]    <= wbs_dat_i[25:24];
        end
        if (wr && ch_hit[c] && w[1:0] == 2'd1) begin
          mul_q[c] <= clk_wr[16 +: PSIZE];
          div_q[c] <= clk_wr[PSIZE-1:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_nec_ir_mregs.sv
// Self-checking bench for nec_ir_mregs: register table plus hand-written
// sequences for FIFO windows, sticky loss, W1C races and reset abort.
module tb_nec_ir_mregs;
  localparam int unsigned NCH = 2, PSIZE = 16, ASIZE = 3;

  logic        clk = 1'b0, rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [6:0]  adr = '0;
  logic [31:0] dat_i = '0;
  logic [3:0]  sel = '0;
  logic [31:0] dat_o;
  logic        ack;
  logic [1:0]  cfg_ir_en, cfg_tx_en, cfg_rx_en, cfg_repeat_en, cfg_rx_pol, cfg_tx_pol;
  logic [3:0]  cfg_tolerance;
  logic [31:0] cfg_multiplier, cfg_divider;
  logic [1:0]  rx_frame_new = '0, rx_full = '0, rx_read, tx_full = '0, tx_write;
  logic [33:0] rx_rdata = '0;
  logic [7:0]  rx_occ = '0, tx_occ = '0;
  logic [15:0] tx_wdata;
  logic        irq;

  nec_ir_mregs #(.NCH(NCH), .PSIZE(PSIZE), .ASIZE(ASIZE)) dut (
    .clk(clk), .rst(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_sel_i(sel), .wbs_dat_o(dat_o), .wbs_ack_o(ack),
    .cfg_ir_en(cfg_ir_en), .cfg_tx_en(cfg_tx_en), .cfg_rx_en(cfg_rx_en),
    .cfg_repeat_en(cfg_repeat_en), .cfg_rx_pol(cfg_rx_pol), .cfg_tx_pol(cfg_tx_pol),
    .cfg_tolerance(cfg_tolerance), .cfg_multiplier(cfg_multiplier), .cfg_divider(cfg_divider),
    .rx_frame_new(rx_frame_new), .fifo_rx_full(rx_full), .fifo_rx_rdata(rx_rdata),
    .fifo_rx_occ(rx_occ), .fifo_rx_read(rx_read), .fifo_tx_full(tx_full),
    .fifo_tx_occ(tx_occ), .fifo_tx_wdata(tx_wdata), .fifo_tx_write(tx_write), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct { bit we; logic [4:0] w; logic [31:0] d; logic [3:0] sel; logic [31:0] exp; } vec_t;
  typedef struct { logic [4:0] w; logic [31:0] d; } rd_t;

  vec_t        tbl [20];
  rd_t         exp_q [$];
  logic [31:0] rx_q [$];
  logic [31:0] tx_q [$];
  rd_t         mon_e;
  int          n_checks = 0, n_fail = 0;
  bit          bus_active = 1'b0, is_read = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic underflow(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %h expected no activity", name, act);
  endtask

  // Scoreboard monitors, sampled mid-cycle
  always @(negedge clk) begin
    if (ack) begin
      if (!bus_active) underflow("spurious_ack", 32'(ack));
      else if (is_read) begin
        if (exp_q.size() == 0) underflow("rd_unqueued", dat_o);
        else begin
          mon_e = exp_q.pop_front();
          chk($sformatf("rd_w%0d", mon_e.w), dat_o, mon_e.d);
        end
      end
    end
    if (rx_read != '0) begin
      if (rx_q.size() == 0) underflow("rx_read_pulse", 32'(rx_read));
      else chk("rx_read_pulse", 32'(rx_read), rx_q.pop_front());
    end
    if (tx_write != '0) begin
      if (tx_q.size() == 0) underflow("tx_write_pulse", {14'd0, tx_write, tx_wdata});
      else chk("tx_write_pulse", {14'd0, tx_write, tx_wdata}, tx_q.pop_front());
    end
  end

  task automatic wb(input bit w_en, input logic [4:0] w, input logic [31:0] d,
                    input logic [3:0] s, input logic [31:0] exp, input bit pulse0);
    int unsigned n;
    @(negedge clk);
    if (!w_en) exp_q.push_back('{w, exp});
    is_read = !w_en; bus_active = 1'b1;
    cyc = 1'b1; stb = 1'b1; we = w_en; adr = {w, 2'b00}; dat_i = d; sel = s;
    if (pulse0) rx_frame_new[0] = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!ack && n < 4);
    rx_frame_new[0] = 1'b0;
    chk($sformatf("ack_latency_w%0d", w), n, 1);
    @(negedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; bus_active = 1'b0;
  endtask

  task automatic wr32(input logic [4:0] w, input logic [31:0] d, input logic [3:0] s);
    wb(1'b1, w, d, s, '0, 1'b0);
  endtask

  task automatic rd32(input logic [4:0] w, input logic [31:0] exp);
    wb(1'b0, w, '0, 4'hF, exp, 1'b0);
  endtask

  task automatic pulse_new(input logic [1:0] nw, input logic [1:0] full);
    @(negedge clk);
    rx_frame_new = nw; rx_full = full;
    @(negedge clk);
    rx_frame_new = '0; rx_full = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b0, 5'd1,  32'h0,         4'hF, 32'h0};
    tbl[1]  = '{1'b0, 5'd2,  32'h0,         4'hF, 32'h0};
    tbl[2]  = '{1'b1, 5'd5,  32'h0003_0007, 4'hF, 32'h0};
    tbl[3]  = '{1'b0, 5'd5,  32'h0,         4'hF, 32'h0003_0007};
    tbl[4]  = '{1'b1, 5'd4,  32'hFFFF_FFFF, 4'hF, 32'h0};
    tbl[5]  = '{1'b0, 5'd4,  32'h0,         4'hF, 32'hFF00_0053};
    tbl[6]  = '{1'b1, 5'd8,  32'hA500_00FF, 4'h7, 32'h0};
    tbl[7]  = '{1'b0, 5'd8,  32'h0,         4'hF, 32'h0100_0000};
    tbl[8]  = '{1'b1, 5'd9,  32'h1234_5678, 4'h5, 32'h0};
    tbl[9]  = '{1'b0, 5'd9,  32'h0,         4'hF, 32'h0034_0078};
    tbl[10] = '{1'b1, 5'd2,  32'hFFFF_FFFF, 4'h3, 32'h0};
    tbl[11] = '{1'b0, 5'd2,  32'h0,         4'hF, 32'h0000_FFFF};
    tbl[12] = '{1'b1, 5'd3,  32'hFFFF_FFFF, 4'hF, 32'h0};
    tbl[13] = '{1'b0, 5'd3,  32'h0,         4'hF, 32'h0};
    tbl[14] = '{1'b0, 5'd31, 32'h0,         4'hF, 32'h0};
    tbl[15] = '{1'b1, 5'd0,  32'h8000_0001, 4'hF, 32'h0};
    tbl[16] = '{1'b0, 5'd0,  32'h0,         4'hF, 32'h8000_0001};
    tbl[17] = '{1'b0, 5'd7,  32'h0,         4'hF, 32'h0};
    tbl[18] = '{1'b1, 5'd12, 32'hFFFF_FFFF, 4'hF, 32'h0};
    tbl[19] = '{1'b0, 5'd12, 32'h0,         4'hF, 32'h0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_dat_o", dat_o, 0);
    chk("rst_tolerance", 32'(cfg_tolerance), 32'h5);
    chk("rst_multiplier", cfg_multiplier, 0);
    chk("rst_ir_en", 32'(cfg_ir_en), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_tx_wdata", 32'(tx_wdata), 0);
    rst = 1'b0;

    rx_occ[3:0] = 4'd3;
    tx_occ[3:0] = 4'd5;
    for (int i = 0; i < 20; i++) wb(tbl[i].we, tbl[i].w, tbl[i].d, tbl[i].sel, tbl[i].exp, 1'b0);
    chk("cfg_multiplier", cfg_multiplier, 32'h0034_0003);
    chk("cfg_divider", cfg_divider, 32'h0078_0007);
    chk("cfg_tolerance", 32'(cfg_tolerance), 32'h7);
    chk("cfg_ir_en_gated_on", 32'(cfg_ir_en), 32'h1);
    chk("cfg_rx_pol", 32'(cfg_rx_pol), 32'h1);

    // TX occupancy draining to zero raises tx_done
    tx_occ[3:0] = 4'd0;
    rx_occ[3:0] = 4'd0;
    repeat (2) @(negedge clk);
    rd32(5'd1, 32'h0001_0000);

    // RX data window on channel 1
    rx_rdata[33:17] = 17'h1_1234;
    rx_occ[7:4] = 4'd2;
    rx_q.push_back(32'h2);
    rd32(5'd10, 32'hC000_1234);
    rx_occ[7:4] = 4'd0;
    rd32(5'd10, 32'h0);

    // Frame lost on channel 0 while its FIFO is full
    pulse_new(2'b01, 2'b01);
    rd32(5'd1, 32'h0001_0101);
    rd32(5'd6, 32'h2000_0000);
    rd32(5'd6, 32'h0);

    // TX push with and without full
    wr32(5'd1, 32'hFFFF_FFFF, 4'hF);
    rd32(5'd1, 32'h0);
    tx_full = 2'b01;
    wr32(5'd7, 32'h0000_ABCD, 4'hF);
    rd32(5'd1, 32'h0100_0000);
    tx_full = 2'b00;
    tx_q.push_back(32'h0001_ABCD);
    wr32(5'd7, 32'h0000_ABCD, 4'hF);
    chk("tx_wdata_hold", 32'(tx_wdata), 32'hABCD);

    // Interrupt, and W1C racing a new set event
    wr32(5'd1, 32'hFFFF_FFFF, 4'hF);
    wr32(5'd2, 32'h0000_0001, 4'hF);
    wr32(5'd0, 32'h0000_0001, 4'hF);
    chk("cfg_ir_en_gated_off", 32'(cfg_ir_en), 0);
    chk("irq_idle", 32'(irq), 0);
    pulse_new(2'b01, 2'b00);
    @(negedge clk);
    chk("irq_raised", 32'(irq), 1);
    wb(1'b1, 5'd1, 32'h1, 4'hF, '0, 1'b1);
    rd32(5'd1, 32'h1);
    chk("irq_held_set_wins", 32'(irq), 1);
    wr32(5'd1, 32'h1, 4'hF);
    rd32(5'd1, 32'h0);
    chk("irq_cleared", 32'(irq), 0);

    // Reset aborting a pending RX read
    rx_occ[7:4] = 4'd2;
    @(negedge clk);
    rst = 1'b1; bus_active = 1'b1; is_read = 1'b1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = {5'd10, 2'b00}; sel = 4'hF;
    @(posedge clk); #1;
    chk("abort_ack", 32'(ack), 0);
    chk("abort_rx_read", 32'(rx_read), 0);
    @(negedge clk);
    chk("abort_multiplier", cfg_multiplier, 0);
    chk("abort_tolerance", 32'(cfg_tolerance), 32'h5);
    chk("abort_tx_en", 32'(cfg_tx_en), 0);
    chk("abort_irq", 32'(irq), 0);
    chk("abort_dat_o", dat_o, 0);
    #1;
    cyc = 1'b0; stb = 1'b0; bus_active = 1'b0; rst = 1'b0;
    rx_q.push_back(32'h2);
    rd32(5'd10, 32'hC000_1234);
    rx_occ[7:4] = 4'd0;

    repeat (3) @(negedge clk);
    chk("rd_queue_drained", 32'(exp_q.size()), 0);
    chk("rx_queue_drained", 32'(rx_q.size()), 0);
    chk("tx_queue_drained", 32'(tx_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
